// File: rtl/rail_seq_pkg.sv
// Shared state type, default timing and the per-state drive vector for the rail sequencer.
// Every state's switch/isolation/reset levels are defined here, so the ordering lives in one table.
package rail_seq_pkg;

    localparam int SETTLE_CYCLES_DEF  = 16;
    localparam int ISO_CYCLES_DEF     = 2;
    localparam int TIMEOUT_CYCLES_DEF = 64;
    localparam int CNT_W_DEF          = 8;

    typedef enum logic [2:0] {
        ST_OFF,
        ST_RAMP,
        ST_SETTLE,
        ST_UNISO,
        ST_ON,
        ST_ISO,
        ST_RAMP_DOWN,
        ST_FAULT
    } rail_state_e;

    typedef struct packed {
        logic rail_en;
        logic iso_en;
        logic dom_rst;
        logic pwr_ack;
    } rail_outs_t;

    // RAMP_DOWN still holds the switch closed; the rail opens on entry to OFF.
    function automatic rail_outs_t state_outputs(input rail_state_e s);
        rail_outs_t o;
        o = '{rail_en: 1'b1, iso_en: 1'b1, dom_rst: 1'b1, pwr_ack: 1'b0};
        case (s)
            ST_OFF, ST_FAULT: o.rail_en = 1'b0;
            ST_UNISO, ST_ISO: o.iso_en  = 1'b0;
            ST_ON: begin
                o.iso_en  = 1'b0;
                o.dom_rst = 1'b0;
                o.pwr_ack = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

    function automatic logic state_busy(input rail_state_e s);
        return !(s inside {ST_OFF, ST_ON, ST_FAULT});
    endfunction

endpackage

// File: rtl/rail_seq_delay_cnt.sv
// Saturating up-counter shared by the settle, isolation and timeout delays.
// Clear wins over load, load wins over increment; done is high once the count reaches i_term.
module rail_seq_delay_cnt
    import rail_seq_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_inc,
    input  logic [CNT_W-1:0] i_term,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_done = (r_cnt >= i_term);

endmodule

// File: rtl/rail_power_sequencer.sv
// Power-up/down sequencer for one gated rail: switch, isolation clamp and domain reset in fixed order.
// Optional pg_good timeout in RAMP is built when RAIL_SEQ_TIMEOUT_EN is defined.
//
//  state     | meaning
//  OFF       | rail open, clamped, in reset
//  RAMP      | switch closed, waiting for pg_good
//  SETTLE    | pg_good seen, letting the rail settle
//  UNISO     | clamp released, reset still held
//  ON        | domain running, pwr_ack high
//  ISO       | reset reasserted, clamp still released
//  RAMP_DOWN | clamp back on, switch opens next
//  FAULT     | rail lost or never good; held until rst
module rail_power_sequencer
    import rail_seq_pkg::*;
#(
    parameter int SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
    parameter int ISO_CYCLES     = ISO_CYCLES_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int CNT_W          = CNT_W_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pwr_req,
    input  logic i_pg_good,
    output logic o_pwr_ack,
    output logic o_rail_en,
    output logic o_iso_en,
    output logic o_dom_rst,
    output logic o_busy,
    output logic o_fault
);

    rail_state_e      r_state;
    rail_state_e      w_state_nxt;
    rail_outs_t       r_outs;
    rail_outs_t       w_outs_nxt;
    logic             r_busy;
    logic             r_fault;
    logic             w_busy_nxt;
    logic             w_fault_nxt;
    logic             w_cnt_clr;
    logic             w_cnt_inc;
    logic             w_cnt_done;
    logic [CNT_W-1:0] w_cnt_term;

    // Outputs are registered from the next state so they change on the same edge as the state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_OFF;
            r_outs  <= state_outputs(ST_OFF);
            r_busy  <= 1'b0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_outs  <= w_outs_nxt;
            r_busy  <= w_busy_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_OFF: begin
                if (i_pwr_req) w_state_nxt = ST_RAMP;
            end
            ST_RAMP: begin
                if (!i_pwr_req)     w_state_nxt = ST_RAMP_DOWN;
                else if (i_pg_good) w_state_nxt = ST_SETTLE;
`ifdef RAIL_SEQ_TIMEOUT_EN
                else if (w_cnt_done) w_state_nxt = ST_FAULT;
`endif
            end
            ST_SETTLE: begin
                if (!i_pg_good)     w_state_nxt = ST_FAULT;
                else if (w_cnt_done) w_state_nxt = ST_UNISO;
            end
            ST_UNISO: begin
                if (w_cnt_done) w_state_nxt = ST_ON;
            end
            ST_ON: begin
                if (!i_pg_good)     w_state_nxt = ST_FAULT;
                else if (!i_pwr_req) w_state_nxt = ST_ISO;
            end
            ST_ISO: begin
                if (w_cnt_done) w_state_nxt = ST_RAMP_DOWN;
            end
            ST_RAMP_DOWN: w_state_nxt = ST_OFF;
            ST_FAULT:     w_state_nxt = ST_FAULT;
            default:      w_state_nxt = ST_OFF;
        endcase
    end

    always_comb begin
        w_outs_nxt  = state_outputs(w_state_nxt);
        w_busy_nxt  = state_busy(w_state_nxt);
        w_fault_nxt = (w_state_nxt == ST_FAULT);
    end

    // Counter restarts on every state change; terminal value is count-1 since the entry edge clears it.
    always_comb begin
        w_cnt_clr  = (w_state_nxt != r_state);
        w_cnt_inc  = 1'b0;
        w_cnt_term = CNT_W'(ISO_CYCLES - 1);
        case (r_state)
            ST_SETTLE: begin
                w_cnt_inc  = 1'b1;
                w_cnt_term = CNT_W'(SETTLE_CYCLES - 1);
            end
            ST_UNISO, ST_ISO: w_cnt_inc = 1'b1;
            ST_RAMP: begin
                w_cnt_term = CNT_W'(TIMEOUT_CYCLES - 1);
`ifdef RAIL_SEQ_TIMEOUT_EN
                w_cnt_inc  = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    rail_seq_delay_cnt #(
        .CNT_W (CNT_W)
    ) u_delay_cnt (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clr      (w_cnt_clr),
        .i_load     (1'b0),
        .i_load_val ('0),
        .i_inc      (w_cnt_inc),
        .i_term     (w_cnt_term),
        .o_done     (w_cnt_done)
    );

    assign o_rail_en = r_outs.rail_en;
    assign o_iso_en  = r_outs.iso_en;
    assign o_dom_rst = r_outs.dom_rst;
    assign o_pwr_ack = r_outs.pwr_ack;
    assign o_busy    = r_busy;
    assign o_fault   = r_fault;

    a_iso_needs_rail: assert property (@(posedge i_clk) disable iff (i_rst) !o_iso_en |-> o_rail_en);
    a_run_needs_uniso: assert property (@(posedge i_clk) disable iff (i_rst) !o_dom_rst |-> !o_iso_en);
    a_ack_only_on: assert property (@(posedge i_clk) disable iff (i_rst) o_pwr_ack |-> (r_state == ST_ON));

endmodule

// File: tb/tb_rail_power_sequencer.sv
// Directed bench for rail_power_sequencer: phase/age model checked every cycle plus literal latency checks.
module tb_rail_power_sequencer;

    localparam int SETTLE = 16;
    localparam int ISO    = 2;
    localparam int TOUT   = 64;

    localparam int PH_IDLE = 0;
    localparam int PH_UP   = 1;
    localparam int PH_ON   = 2;
    localparam int PH_DOWN = 3;
    localparam int PH_FLT  = 4;

    logic clk = 1'b0;
    logic rst, req, pg;
    logic ack, rail, iso, drst, busy, fault;

    int cyc     = 0;
    int n_pass  = 0;
    int n_total = 0;

    rail_power_sequencer #(
        .SETTLE_CYCLES  (SETTLE),
        .ISO_CYCLES     (ISO),
        .TIMEOUT_CYCLES (TOUT),
        .CNT_W          (8)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_pwr_req (req),
        .i_pg_good (pg),
        .o_pwr_ack (ack),
        .o_rail_en (rail),
        .o_iso_en  (iso),
        .o_dom_rst (drst),
        .o_busy    (busy),
        .o_fault   (fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    endtask

    // Model: phase plus edges since phase entry; pg_at is the age at which pg_good was first seen.
    int ph, age, pg_at, hold;
    bit m_valid = 1'b0;
    logic [5:0] m_exp;

    always @(posedge clk) begin
        if (rst) begin
            ph = PH_IDLE; age = 0; pg_at = -1; hold = 0; m_valid = 1'b1;
        end else if (m_valid) begin
            case (ph)
                PH_IDLE: if (req) begin ph = PH_UP; age = 0; pg_at = -1; end
                PH_UP: begin
                    age++;
                    if (pg_at < 0) begin
                        if (!req) begin ph = PH_DOWN; age = 0; hold = 0; end
                        else if (pg) pg_at = age;
`ifdef RAIL_SEQ_TIMEOUT_EN
                        else if (age >= TOUT) ph = PH_FLT;
`endif
                    end else if (age <= pg_at + SETTLE && !pg) begin
                        ph = PH_FLT;
                    end else if (age == pg_at + SETTLE + ISO) begin
                        ph = PH_ON;
                    end
                end
                PH_ON: begin
                    if (!pg) ph = PH_FLT;
                    else if (!req) begin ph = PH_DOWN; age = 0; hold = ISO; end
                end
                PH_DOWN: begin
                    age++;
                    if (age > hold) ph = PH_IDLE;
                end
                default: ph = PH_FLT;
            endcase
        end
    end

    // Expected {rail, iso, dom_rst, ack, busy, fault}
    always @(negedge clk) begin
        if (m_valid) begin
            case (ph)
                PH_IDLE: m_exp = 6'b011000;
                PH_UP:   m_exp = {1'b1, !(pg_at >= 0 && age >= pg_at + SETTLE), 1'b1, 1'b0, 1'b1, 1'b0};
                PH_ON:   m_exp = 6'b100100;
                PH_DOWN: m_exp = {1'b1, (age >= hold), 1'b1, 1'b0, 1'b1, 1'b0};
                default: m_exp = 6'b011001;
            endcase
            check("model", {26'd0, rail, iso, drst, ack, busy, fault}, {26'd0, m_exp});
        end
    end

    function automatic logic sel_out(input int s);
        case (s)
            0:       return rail;
            1:       return iso;
            2:       return drst;
            3:       return ack;
            default: return fault;
        endcase
    endfunction

    task automatic wait_out(input int s, input logic v, input int maxc, output int t);
        t = -100000;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (sel_out(s) === v) begin
                t = cyc;
                return;
            end
        end
        n_total++;
        $display("FAIL wait timeout: output %0d never reached %0b within %0d cycles", s, v, maxc);
    endtask

    int c0, t1, t2, t3;

    initial begin
        rst = 1'b1; req = 1'b0; pg = 1'b0;
        repeat (2) @(negedge clk);
        check("reset values", {26'd0, rail, iso, drst, ack, busy, fault}, 32'b011000);
        rst = 1'b0;
        @(negedge clk);

        // Power-up, pg_good arrives 3 cycles after rail_en
        c0 = cyc; req = 1'b1;
        wait_out(0, 1'b1, 5, t1);
        check("rail_en rise latency", t1 - c0, 1);
        repeat (2) @(negedge clk);
        pg = 1'b1;
        wait_out(1, 1'b0, 40, t2);
        check("iso release after rail_en", t2 - t1, 3 + SETTLE);
        wait_out(2, 1'b0, 10, t3);
        check("dom_rst after iso", t3 - t2, ISO);
        check("ack with dom_rst", ack, 1);

        // Power-down from ON
        @(negedge clk);
        c0 = cyc; req = 1'b0;
        wait_out(3, 1'b0, 5, t1);
        check("ack fall latency", t1 - c0, 1);
        check("dom_rst with ack fall", drst, 1);
        wait_out(1, 1'b1, 10, t2);
        check("iso reassert delay", t2 - t1, ISO);
        wait_out(0, 1'b0, 10, t3);
        check("rail_en fall latency", t3 - c0, ISO + 2);
        check("busy low when off", busy, 0);

        // Power-up with pg_good already high; req toggle inside UNISO is ignored
        @(negedge clk);
        c0 = cyc; req = 1'b1;
        wait_out(1, 1'b0, 40, t1);
        check("iso release, pg early", t1 - c0, 2 + SETTLE);
        req = 1'b0;
        @(negedge clk);
        req = 1'b1;
        wait_out(3, 1'b1, 10, t2);
        check("ack rise latency", t2 - c0, 2 + SETTLE + ISO);

        // req toggle inside ISO is ignored; OFF then picks up req again, then abort in RAMP
        @(negedge clk);
        c0 = cyc; req = 1'b0;
        @(negedge clk);
        req = 1'b1;
        wait_out(0, 1'b0, 10, t1);
        check("rail fall despite req in ISO", t1 - c0, ISO + 2);
        wait_out(0, 1'b1, 5, t2);
        check("OFF re-evaluates req", t2 - t1, 1);
        pg = 1'b0; req = 1'b0;
        wait_out(0, 1'b0, 5, t3);
        check("abort rail fall", t3 - t2, 2);
        check("abort no ack", ack, 0);
        check("abort no fault", fault, 0);

        // Brown-out while ON
        pg = 1'b1; req = 1'b1;
        wait_out(3, 1'b1, 40, t1);
        @(negedge clk);
        pg = 1'b0;
        @(negedge clk);
        check("brownout outputs", {27'd0, fault, rail, iso, drst, ack}, 32'b10110);
        req = 1'b0;
        repeat (5) @(negedge clk);
        req = 1'b1;
        repeat (5) @(negedge clk);
        check("fault sticky", {27'd0, fault, rail, iso, drst, busy}, 32'b10110);
        rst = 1'b1;
        @(negedge clk);
        check("reset clears fault", {26'd0, rail, iso, drst, ack, busy, fault}, 32'b011000);

        // Reset in the middle of SETTLE
        rst = 1'b0; pg = 1'b1;
        repeat (6) @(negedge clk);
        check("mid settle", {30'd0, busy, iso}, 32'b11);
        rst = 1'b1; req = 1'b0;
        @(negedge clk);
        check("reset mid settle", {26'd0, rail, iso, drst, ack, busy, fault}, 32'b011000);
        rst = 1'b0; pg = 1'b0;
        @(negedge clk);

        // pg_good never arrives
        c0 = cyc; req = 1'b1;
        wait_out(0, 1'b1, 5, t1);
`ifdef RAIL_SEQ_TIMEOUT_EN
        wait_out(4, 1'b1, TOUT + 10, t2);
        check("timeout fault latency", t2 - t1, TOUT);
`else
        repeat (1000) @(negedge clk);
        check("no timeout without feature", {29'd0, fault, rail, busy}, 32'b011);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
